// File: rtl/spi_adc_scanner.sv
// Multi-channel SPI ADC controller (ADC128S022 style): single-shot and round-robin scan.
// Results are tagged with the channel addressed in the previous frame, matching the ADC pipeline.
module spi_adc_scanner #(
    parameter int CLK_DIV      = 8,
    parameter int FRAME_BITS   = 16,
    parameter int DATA_BITS    = 12,
    parameter int NUM_CH       = 8,
    parameter int ADDR_BITS    = 3,
    parameter int ADDR_POS     = 2,
    parameter int QUIET_CYCLES = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] ch_sel,
    input  logic                 scan_en,
    output logic                 cs_bar,
    output logic                 sclk,
    output logic                 din,
    input  logic                 sdata,
    output logic [DATA_BITS-1:0] data_out,
    output logic [ADDR_BITS-1:0] ch_out,
    output logic                 data_valid,
    output logic                 busy
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] QUIET = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam int CNT_MAX = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FRAME_BITS + 1);

    logic [2:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [BIT_W-1:0]      r_bit;
    logic                  r_phase;     // 0 = SCLK low half, 1 = SCLK high half
    logic                  r_scan;
    logic                  r_prime;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [ADDR_BITS-1:0]  r_prev_addr;
    logic [ADDR_BITS-1:0]  r_scan_ptr;
    logic [FRAME_BITS-1:0] r_cap;
    logic                  r_cs_bar;
    logic                  r_sclk;
    logic                  r_din;
    logic [DATA_BITS-1:0]  r_data;
    logic [ADDR_BITS-1:0]  r_ch;
    logic                  r_valid;

    logic                  w_div_end;
    logic                  w_quiet_end;
    logic                  w_last_bit;
    logic [ADDR_BITS-1:0]  w_next_ptr;

    // Address word bit for frame bit i: address MSB-first starting at ADDR_POS, zero elsewhere.
    function automatic logic addr_bit(input logic [ADDR_BITS-1:0] a, input int i);
        if (i >= ADDR_POS && i < ADDR_POS + ADDR_BITS)
            return a[ADDR_BITS-1-(i-ADDR_POS)];
        return 1'b0;
    endfunction

    assign w_div_end   = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign w_quiet_end = (r_cnt == CNT_W'(QUIET_CYCLES - 1));
    assign w_last_bit  = (r_bit == BIT_W'(FRAME_BITS - 1));
    assign w_next_ptr  = (r_scan_ptr == ADDR_BITS'(NUM_CH - 1)) ? '0 : r_scan_ptr + ADDR_BITS'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_phase     <= 1'b0;
            r_scan      <= 1'b0;
            r_prime     <= 1'b0;
            r_addr      <= '0;
            r_prev_addr <= '0;
            r_scan_ptr  <= '0;
            r_cap       <= '0;
            r_cs_bar    <= 1'b1;
            r_sclk      <= 1'b1;
            r_din       <= 1'b0;
            r_data      <= '0;
            r_ch        <= '0;
            r_valid     <= 1'b0;
        end else begin
            // NOTE: default-clear each cycle so data_valid can only ever be a single-cycle pulse.
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (scan_en) begin
                        r_addr   <= r_scan_ptr;
                        r_scan   <= 1'b1;
                        r_prime  <= 1'b0;
                        r_state  <= SETUP;
                        r_cs_bar <= 1'b0;
                        r_sclk   <= 1'b1;
                        r_cnt    <= '0;
                    end else if (start) begin
                        r_addr   <= ch_sel;
                        r_scan   <= 1'b0;
                        r_prime  <= (ch_sel != r_prev_addr);
                        r_state  <= SETUP;
                        r_cs_bar <= 1'b0;
                        r_sclk   <= 1'b1;
                        r_cnt    <= '0;
                    end
                end
                SETUP: begin
                    if (w_div_end) begin
                        r_state <= SHIFT;
                        r_sclk  <= 1'b0;
                        r_din   <= addr_bit(r_addr, 0);
                        r_bit   <= '0;
                        r_phase <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    if (!w_div_end) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_cnt <= '0;
                        if (!r_phase) begin
                            r_sclk  <= 1'b1;
                            r_phase <= 1'b1;
                            r_cap   <= {r_cap[FRAME_BITS-2:0], sdata};
                        end else if (w_last_bit) begin
                            r_cs_bar <= 1'b1;
                            r_sclk   <= 1'b1;
                            r_din    <= 1'b0;
                            r_state  <= QUIET;
                        end else begin
                            r_sclk  <= 1'b0;
                            r_phase <= 1'b0;
                            r_bit   <= r_bit + BIT_W'(1);
                            r_din   <= addr_bit(r_addr, int'(r_bit) + 1);
                        end
                    end
                end
                QUIET: begin
                    if (w_quiet_end) begin
                        // Result belongs to the previously addressed channel; publish on entry to DONE.
                        r_state     <= DONE;
                        r_prev_addr <= r_addr;
                        if (!r_prime) begin
                            r_data  <= r_cap[DATA_BITS-1:0];
                            r_ch    <= r_prev_addr;
                            r_valid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_cnt <= '0;
                    if (r_scan) begin
                        r_scan_ptr <= w_next_ptr;
                        if (scan_en) begin
                            r_addr   <= w_next_ptr;
                            r_state  <= SETUP;
                            r_cs_bar <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (r_prime) begin
                        r_prime  <= 1'b0;
                        r_state  <= SETUP;
                        r_cs_bar <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cs_bar     = r_cs_bar;
    assign sclk       = r_sclk;
    assign din        = r_din;
    assign data_out   = r_data;
    assign ch_out     = r_ch;
    assign data_valid = r_valid;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_spi_adc_scanner.sv
// Directed self-checking bench for spi_adc_scanner with a behavioural ADC model.
// The model drives sdata on SCLK falls and logs DIN address words, frame lengths and results.
module tb_spi_adc_scanner;

    localparam int CLK_DIV = 2;

    logic        clk = 1'b0;
    logic        rst, start, scan_en, sdata;
    logic [2:0]  ch_sel;
    logic        cs_bar, sclk, din, data_valid, busy;
    logic [11:0] data_out;
    logic [2:0]  ch_out;

    always #5 clk = ~clk;

    spi_adc_scanner #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .start(start), .ch_sel(ch_sel), .scan_en(scan_en),
        .cs_bar(cs_bar), .sclk(sclk), .din(din), .sdata(sdata),
        .data_out(data_out), .ch_out(ch_out), .data_valid(data_valid), .busy(busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ADC model state and transaction logs
    logic        model_const = 1'b1;   // 1: return 0x4ABC, 0: return 0x0100 + previous frame address
    logic [2:0]  model_prev  = 3'd0;
    logic [15:0] model_word  = 16'h0;
    logic        prev_sclk   = 1'b1;
    logic        prev_cs     = 1'b1;
    logic [15:0] din_word    = 16'h0;
    int          cs_len      = 0;
    int          sclk_rises  = 0;
    int          q_len[$];
    logic [15:0] q_din[$];
    logic [11:0] q_data[$];
    logic [2:0]  q_ch[$];

    initial sdata = 1'b0;

    always @(negedge clk) begin
        if (cs_bar == 1'b0) begin
            if (prev_cs) begin
                cs_len     = 1;
                din_word   = 16'h0;
                sclk_rises = 0;
                model_word = model_const ? 16'h4ABC : (16'h0100 + 16'(model_prev));
            end else begin
                cs_len++;
            end
            if (prev_sclk && !sclk) begin
                sdata      = model_word[15];
                model_word = model_word << 1;
            end
            if (!prev_sclk && sclk) begin
                din_word = {din_word[14:0], din};
                sclk_rises++;
            end
        end else if (!prev_cs) begin
            q_len.push_back(cs_len);
            q_din.push_back(din_word);
            model_prev = din_word[13:11];
        end
        if (data_valid) begin
            q_data.push_back(data_out);
            q_ch.push_back(ch_out);
        end
        prev_sclk = sclk;
        prev_cs   = cs_bar;
    end

    task automatic clear_logs();
        q_len.delete();
        q_din.delete();
        q_data.delete();
        q_ch.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_logs();
        model_prev = 3'd0;
    endtask

    task automatic pulse_start(input logic [2:0] ch);
        @(negedge clk);
        ch_sel = ch;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk({tag, "_idle_timeout"}, busy, 0);
    endtask

    task automatic check_frames(input string tag, input int n_exp, input logic [2:0] addr_exp);
        chk({tag, "_frames"}, q_len.size(), n_exp);
        for (int i = 0; i < q_len.size(); i++) begin
            chk($sformatf("%s_cslow%0d", tag, i), q_len[i], CLK_DIV * 33);
            chk($sformatf("%s_addr%0d", tag, i), q_din[i][13:11], addr_exp);
            chk($sformatf("%s_dinzero%0d", tag, i), q_din[i] & 16'hC7FF, 0);
        end
    endtask

    initial begin
        int bad;
        int n;
        rst = 1'b1; start = 1'b0; scan_en = 1'b0; ch_sel = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (cs_bar !== 1'b1 || sclk !== 1'b1 || din !== 1'b0 || busy !== 1'b0 || data_valid !== 1'b0)
                bad++;
        end
        chk("idle_glitches", bad, 0);
        chk("idle_cs_bar", cs_bar, 1);
        chk("idle_sclk", sclk, 1);
        chk("idle_din", din, 0);
        chk("idle_busy", busy, 0);
        chk("idle_data_out", data_out, 0);
        chk("idle_ch_out", ch_out, 0);
        chk("idle_no_valid", q_data.size(), 0);

        // Single shot to channel 3 from reset: priming frame plus one result frame
        pulse_start(3'd3);
        chk("ss1_busy", busy, 1);
        wait_idle("ss1", 1000);
        check_frames("ss1", 2, 3'd3);
        chk("ss1_valid_count", q_data.size(), 1);
        chk("ss1_data", q_data[0], 12'hABC);
        chk("ss1_ch", q_ch[0], 3);
        chk("ss1_hold_data", data_out, 12'hABC);
        chk("ss1_hold_ch", ch_out, 3);
        clear_logs();

        // Same channel again: no priming
        pulse_start(3'd3);
        wait_idle("ss2", 1000);
        check_frames("ss2", 1, 3'd3);
        chk("ss2_valid_count", q_data.size(), 1);
        chk("ss2_data", q_data[0], 12'hABC);
        chk("ss2_ch", q_ch[0], 3);

        // Round-robin scan from reset; stop in the middle of the ninth frame
        do_reset();
        model_const = 1'b0;
        @(negedge clk);
        scan_en = 1'b1;
        n = 0;
        while (q_data.size() < 8 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("scan_progress_timeout", q_data.size(), 8);
        repeat (20) @(negedge clk);
        chk("scan_stop_midframe", cs_bar, 0);
        scan_en = 1'b0;
        wait_idle("scan", 1000);
        chk("scan_busy_after", busy, 0);
        chk("scan_frames", q_din.size(), 9);
        for (int i = 0; i < q_din.size(); i++)
            chk($sformatf("scan_addr%0d", i), q_din[i][13:11], i % 8);
        chk("scan_valid_count", q_data.size(), 9);
        for (int i = 0; i < q_data.size(); i++) begin
            chk($sformatf("scan_tag%0d", i), q_ch[i], (i == 0) ? 0 : i - 1);
            chk($sformatf("scan_data%0d", i), q_data[i], 12'h100 + ((i == 0) ? 0 : i - 1));
        end

        // Reset during bit 7 of a frame
        model_const = 1'b1;
        clear_logs();
        pulse_start(3'd2);
        n = 0;
        while (!(sclk_rises == 7 && sclk == 1'b0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("rst_bit7_timeout", sclk_rises, 7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_cs_bar", cs_bar, 1);
        chk("rst_mid_sclk", sclk, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_valid", data_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_no_result", q_data.size(), 0);
        clear_logs();
        model_prev = 3'd0;
        pulse_start(3'd0);
        wait_idle("rst_ss", 1000);
        check_frames("rst_ss", 1, 3'd0);
        chk("rst_ss_valid_count", q_data.size(), 1);
        chk("rst_ss_data", q_data[0], 12'hABC);
        chk("rst_ss_ch", q_ch[0], 0);

        // start and scan_en together: scan wins, ch_sel ignored
        do_reset();
        model_const = 1'b0;
        @(negedge clk);
        ch_sel = 3'd5; start = 1'b1; scan_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (q_len.size() < 1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("both_frame_timeout", q_len.size(), 1);
        scan_en = 1'b0;
        wait_idle("both", 500);
        chk("both_frames", q_din.size(), 1);
        chk("both_addr", q_din[0][13:11], 0);
        chk("both_valid_count", q_data.size(), 1);
        chk("both_ch", q_ch[0], 0);
        chk("both_data", q_data[0], 12'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

endmodule
